// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, FSM encoding, S-box and GF(2^8) helpers
package aes_pkg;

    localparam int AES_WIDTH     = 8;
    localparam int AES_DIM       = 4;
    localparam int AES_MAX_ROUND = 10;

    typedef logic [7:0]                                byte_t;
    typedef logic [31:0]                               word_t;
    typedef logic [127:0]                              key_t;
    typedef logic [AES_DIM*AES_DIM*AES_WIDTH-1:0]      state_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ark_state_e;

    localparam byte_t RCON_INIT = 8'h01;

    // Forward S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX_TABLE[8*(255-int'(b)) +: 8];
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_sched_step.sv
// rtl/key_sched_step.sv - one combinational AES-128 key-schedule round
module key_sched_step
    import aes_pkg::*;
(
    input  key_t  key_i,
    input  byte_t rcon_i,
    output key_t  key_o
);

    word_t t;
    word_t w0, w1, w2, w3;

    // Word c holds bytes 4c..4c+3 with byte 4c in the low bits; RotWord moves byte 13 to the front
    always_comb begin
        t[7:0]   = sbox(key_i[8*13 +: 8]) ^ rcon_i;
        t[15:8]  = sbox(key_i[8*14 +: 8]);
        t[23:16] = sbox(key_i[8*15 +: 8]);
        t[31:24] = sbox(key_i[8*12 +: 8]);
        w0       = key_i[31:0]   ^ t;
        w1       = key_i[63:32]  ^ w0;
        w2       = key_i[95:64]  ^ w1;
        w3       = key_i[127:96] ^ w2;
        key_o    = {w3, w2, w1, w0};
    end

endmodule

// File: rtl/add_round_key.sv
// rtl/add_round_key.sv - AddRoundKey with iterative key expansion; ARK_KEY_OUT_EN adds key_o
module add_round_key
    import aes_pkg::*;
#(
    parameter int WIDTH     = AES_WIDTH,
    parameter int DIM       = AES_DIM,
    parameter int MAX_ROUND = AES_MAX_ROUND
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [DIM*DIM*WIDTH-1:0] state_i,
    input  logic [127:0]             key_i,
    input  logic [3:0]               round_i,
    output logic                     valid_o,
    input  logic                     ready_i,
`ifdef ARK_KEY_OUT_EN
    output logic [127:0]             key_o,
`endif
    output logic [DIM*DIM*WIDTH-1:0] state_o
);

    if (WIDTH != 8 || DIM != 4) begin : g_bad_param
        $error("add_round_key: WIDTH must be 8 and DIM must be 4");
    end

    ark_state_e state_q, state_d;
    state_vec_t data_q;
    key_t       key_q;
    key_t       key_next;
    byte_t      rcon_q;
    logic [3:0] round_q;
    logic [3:0] cnt_q;
    logic [3:0] round_sat;
    logic       accept;

    assign round_sat = (round_i > 4'(MAX_ROUND)) ? 4'(MAX_ROUND) : round_i;
    assign accept    = (state_q == IDLE) && valid_i;

    key_sched_step u_step (
        .key_i  (key_q),
        .rcon_i (rcon_q),
        .key_o  (key_next)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: round 0 skips expansion, expansion ends on the r-th step
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = (round_sat != 4'd0) ? EXPAND : DONE;
            EXPAND:  if (cnt_q + 4'd1 == round_q) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on accept, advance key and rcon once per EXPAND cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            key_q   <= '0;
            rcon_q  <= '0;
            round_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            data_q  <= state_i;
            key_q   <= key_i;
            rcon_q  <= RCON_INIT;
            round_q <= round_sat;
            cnt_q   <= '0;
        end else if (state_q == EXPAND) begin
            key_q   <= key_next;
            rcon_q  <= xtime(rcon_q);
            cnt_q   <= cnt_q + 4'd1;
        end
    end

    // Outputs: result only visible in DONE, ready suppressed while reset is held
    always_comb begin
        ready_o = (state_q == IDLE) && !rst_i;
        valid_o = (state_q == DONE);
        state_o = (state_q == DONE) ? (data_q ^ key_q) : '0;
`ifdef ARK_KEY_OUT_EN
        key_o   = (state_q == DONE) ? key_q : '0;
`endif
    end

endmodule

// File: tb/tb_add_round_key.sv
// tb/tb_add_round_key.sv - randomized self-checking bench for add_round_key
module tb_add_round_key;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] state_i;
    logic [127:0] key_i;
    logic [3:0]   round_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] state_o;
`ifdef ARK_KEY_OUT_EN
    logic [127:0] key_o;
`endif

    int checks   = 0;
    int failures = 0;

    add_round_key dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .state_i (state_i),
        .key_i   (key_i),
        .round_i (round_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
`ifdef ARK_KEY_OUT_EN
        .key_o   (key_o),
`endif
        .state_o (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00)
            for (int x = 1; x < 256; x++)
                if (gf_mul(a, 8'(x)) == 8'h01) inv = 8'(x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // FIPS-197 word expansion on a byte array; returns round key r packed with byte k at [8k+:8]
    function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int r);
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc = 8'h01;
        logic [7:0] t0;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) w[k] = key[8*k +: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                t0 = tmp[0];
                tmp[0] = ref_sbox(tmp[1]) ^ rc;
                tmp[1] = ref_sbox(tmp[2]);
                tmp[2] = ref_sbox(tmp[3]);
                tmp[3] = ref_sbox(t0);
                rc = gf_mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int k = 0; k < 16; k++) res[8*k +: 8] = w[16*r + k];
        return res;
    endfunction

    function automatic logic [127:0] ref_result(input logic [127:0] st, input logic [127:0] key,
                                                input int rnd);
        int r = (rnd > 10) ? 10 : rnd;
        return st ^ ref_round_key(key, r);
    endfunction

    // Converts a hex string written byte 0 first into the byte-k-at-[8k+:8] layout
    function automatic logic [127:0] bs(input logic [127:0] h);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = h[8*(15-k) +: 8];
        return r;
    endfunction

    // ---------------- stimulus helper ----------------
    // Accepts one transaction with ready_i high; lat counts edges from accept (inclusive) to valid_o
    task automatic run_txn(input logic [127:0] st, input logic [127:0] k, input logic [3:0] rnd,
                           output logic [127:0] res, output int lat);
        int guard = 0;
        @(negedge clk_i);
        valid_i = 1'b1; state_i = st; key_i = k; round_i = rnd; ready_i = 1'b1;
        while (!ready_o && guard < 50) begin @(negedge clk_i); guard++; end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin @(posedge clk_i); #1; lat++; end
        res = state_o;
        @(posedge clk_i); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        state_i = '0; key_i = '0; round_i = '0;
        #2;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        checks++; if (state_o !== 128'h0) begin failures++; $display("FAIL reset_state got=%h want=0", state_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", ready_o); end
    endtask

    task automatic test_known_answers();
        logic [127:0] res;
        int lat;
        logic [127:0] fips_key = bs(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_txn('0, fips_key, 4'd1, res, lat);
        checks++; if (res !== bs(128'ha0fafe1788542cb123a339392a6c7605)) begin failures++; $display("FAIL kat_r1_data got=%h want=%h", res, bs(128'ha0fafe1788542cb123a339392a6c7605)); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL kat_r1_latency got=%0d want=2", lat); end
        run_txn('0, fips_key, 4'd10, res, lat);
        checks++; if (res !== bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin failures++; $display("FAIL kat_r10_data got=%h want=%h", res, bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)); end
        checks++; if (lat !== 11) begin failures++; $display("FAIL kat_r10_latency got=%0d want=11", lat); end
    endtask

    task automatic test_round0();
        logic [127:0] res;
        int lat;
        run_txn(bs(128'h00112233445566778899aabbccddeeff), bs(128'h000102030405060708090a0b0c0d0e0f),
                4'd0, res, lat);
        checks++; if (res !== bs(128'h00102030405060708090a0b0c0d0e0f0)) begin failures++; $display("FAIL round0_data got=%h want=%h", res, bs(128'h00102030405060708090a0b0c0d0e0f0)); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL round0_latency got=%0d want=1", lat); end
    endtask

    task automatic test_saturation();
        logic [127:0] res;
        int lat;
        run_txn('0, bs(128'h2b7e151628aed2a6abf7158809cf4f3c), 4'd15, res, lat);
        checks++; if (res !== bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin failures++; $display("FAIL sat_r15_data got=%h want=%h", res, bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)); end
        checks++; if (lat !== 11) begin failures++; $display("FAIL sat_r15_latency got=%0d want=11", lat); end
    endtask

    task automatic test_backpressure();
        logic [127:0] st = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] k  = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] want = ref_result(st, k, 3);
        logic [127:0] held;
        int guard = 0;
        @(negedge clk_i);
        valid_i = 1'b1; state_i = st; key_i = k; round_i = 4'd3; ready_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        // Pulse valid_i with different data and changed key while expanding
        @(negedge clk_i);
        valid_i = 1'b1; state_i = ~st; key_i = ~k; round_i = 4'd0;
        @(negedge clk_i); valid_i = 1'b0;
        while (!valid_o && guard < 40) begin @(posedge clk_i); #1; guard++; end
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b want=1", valid_o); end
        held = state_o;
        checks++; if (held !== want) begin failures++; $display("FAIL bp_data got=%h want=%h", held, want); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            checks++; if (state_o !== want || valid_o !== 1'b1 || ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d state=%h valid=%b ready=%b want state=%h valid=1 ready=0",
                         c, state_o, valid_o, ready_o, want);
            end
        end
        @(negedge clk_i); ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL bp_release ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o); end
    endtask

    task automatic test_async_reset();
        logic [127:0] res;
        int lat;
        logic [127:0] fips_key = bs(128'h2b7e151628aed2a6abf7158809cf4f3c);
        @(negedge clk_i);
        valid_i = 1'b1; state_i = '1; key_i = fips_key; round_i = 4'd10; ready_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0 || state_o !== 128'h0) begin failures++; $display("FAIL arst_outputs valid=%b state=%h want valid=0 state=0", valid_o, state_o); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b want=0", ready_o); end
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL arst_held ready=%b valid=%b want 0 0", ready_o, valid_o); end
        @(negedge clk_i); rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL arst_release_ready got=%b want=1", ready_o); end
        run_txn('0, fips_key, 4'd1, res, lat);
        checks++; if (res !== bs(128'ha0fafe1788542cb123a339392a6c7605) || lat !== 2) begin failures++; $display("FAIL arst_after_txn got=%h lat=%0d want=%h lat=2", res, lat, bs(128'ha0fafe1788542cb123a339392a6c7605)); end
    endtask

    task automatic test_random();
        logic [127:0] res, st, k, want;
        logic [3:0] rnd;
        int lat, want_lat;
        for (int n = 0; n < 12; n++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            k   = {$urandom, $urandom, $urandom, $urandom};
            rnd = 4'($urandom_range(0, 15));
            want = ref_result(st, k, int'(rnd));
            want_lat = ((rnd > 4'd10) ? 10 : int'(rnd)) + 1;
            run_txn(st, k, rnd, res, lat);
            checks++; if (res !== want) begin failures++; $display("FAIL rand_data n=%0d round=%0d got=%h want=%h", n, rnd, res, want); end
            checks++; if (lat !== want_lat) begin failures++; $display("FAIL rand_latency n=%0d round=%0d got=%0d want=%0d", n, rnd, lat, want_lat); end
        end
    endtask

    initial begin
        test_reset();
        test_known_answers();
        test_round0();
        test_saturation();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
